// File: rtl/count_reporter.sv
// count_reporter: checks the sample counter stream for continuity and, on request
// or a periodic timer, reports a count snapshot as an ASCII line over 8N1 UART.
module count_reporter #(
    parameter int unsigned CLKS_PER_BIT  = 417,
    parameter int unsigned REPORT_PERIOD = 48000000
) (
    input  logic        clock48,
    input  logic        rst,
    input  logic [31:0] counts,
    input  logic        inited,
    input  logic        reseted,
    input  logic        report_req,
    output logic        uart_tx,
    output logic        busy,
    output logic        err_flag,
    output logic [15:0] err_count,
    output logic [3:0]  o_dbg_state
);
    localparam int BW = $clog2(CLKS_PER_BIT);
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {F_IDLE, F_SEND, F_DONE} fstate_t;
    typedef enum logic [1:0] {T_IDLE, T_START, T_DATA, T_STOP} tstate_t;

    fstate_t        r_fstate;
    tstate_t        r_tstate;
    logic [BW-1:0]  r_baud;
    logic [2:0]     r_bit;
    logic [3:0]     r_char;
    logic [7:0]     r_shift;
    logic [31:0]    r_snap;
    logic           r_rs;
    logic           r_tx;
    logic           r_busy;
    logic [31:0]    r_timer;
    logic [31:0]    r_prev;
    logic           r_prev_valid;
    logic           r_err_flag;
    logic [15:0]    r_err_count;

    logic w_idle;
    logic w_expire;
    logic w_trigger;
    logic w_baud_end;
    logic w_err;

    // Character idx of the line "<R|C><8 hex digits>\r\n" for a given snapshot.
    function automatic logic [7:0] frame_char(input logic [3:0] idx,
                                              input logic [31:0] snap,
                                              input logic rs);
        logic [31:0] sh;
        logic [3:0]  nib;
        sh  = snap << {idx - 4'd1, 2'b00};
        nib = sh[31:28];
        if (idx == 4'd0)       return rs ? 8'h52 : 8'h43;
        else if (idx == 4'd9)  return 8'h0D;
        else if (idx == 4'd10) return 8'h0A;
        else if (nib < 4'd10)  return 8'h30 + {4'h0, nib};
        else                   return 8'h37 + {4'h0, nib};
    endfunction

    // DONE counts as idle so a trigger lands on the first cycle busy is low.
    assign w_idle     = (r_fstate != F_SEND);
    assign w_expire   = (REPORT_PERIOD != 0) && (r_timer == 32'(REPORT_PERIOD - 1));
    assign w_trigger  = inited && w_idle && (report_req || w_expire);
    assign w_baud_end = (r_baud == BAUD_LAST);
    assign w_err      = inited && r_prev_valid && (counts != 32'd0) &&
                        (counts != r_prev + 32'd1);

    always_ff @(posedge clock48) begin
        if (rst) begin
            r_prev       <= '0;
            r_prev_valid <= 1'b0;
            r_err_flag   <= 1'b0;
            r_err_count  <= '0;
        end else begin
            if (inited) begin
                r_prev       <= counts;
                r_prev_valid <= 1'b1;
            end else begin
                r_prev_valid <= 1'b0;
            end
            if (w_err) begin
                r_err_flag <= 1'b1;
                if (r_err_count != 16'hFFFF) r_err_count <= r_err_count + 16'd1;
            end
        end
    end

    // Expiry while busy is dropped: the timer restarts either way.
    always_ff @(posedge clock48) begin
        if (rst) begin
            r_timer <= '0;
        end else if (inited) begin
            if (w_trigger || w_expire) r_timer <= '0;
            else                       r_timer <= r_timer + 32'd1;
        end
    end

    always_ff @(posedge clock48) begin
        if (rst) begin
            r_fstate <= F_IDLE;
            r_tstate <= T_IDLE;
            r_baud   <= '0;
            r_bit    <= '0;
            r_char   <= '0;
            r_shift  <= '0;
            r_snap   <= '0;
            r_rs     <= 1'b0;
            r_tx     <= 1'b1;
            r_busy   <= 1'b0;
        end else begin
            case (r_fstate)
                F_IDLE, F_DONE: begin
                    r_fstate <= F_IDLE;
                    if (w_trigger) begin
                        r_fstate <= F_SEND;
                        r_tstate <= T_START;
                        r_snap   <= counts;
                        r_rs     <= reseted;
                        r_char   <= 4'd0;
                        r_baud   <= '0;
                        r_shift  <= frame_char(4'd0, counts, reseted);
                        r_tx     <= 1'b0;
                        r_busy   <= 1'b1;
                    end
                end
                F_SEND: begin
                    r_baud <= w_baud_end ? '0 : r_baud + BW'(1);
                    if (w_baud_end) begin
                        case (r_tstate)
                            T_START: begin
                                r_tstate <= T_DATA;
                                r_bit    <= 3'd0;
                                r_tx     <= r_shift[0];
                            end
                            T_DATA: begin
                                if (r_bit == 3'd7) begin
                                    r_tstate <= T_STOP;
                                    r_tx     <= 1'b1;
                                end else begin
                                    r_bit   <= r_bit + 3'd1;
                                    r_shift <= {1'b0, r_shift[7:1]};
                                    r_tx    <= r_shift[1];
                                end
                            end
                            T_STOP: begin
                                if (r_char == 4'd10) begin
                                    r_tstate <= T_IDLE;
                                    r_fstate <= F_DONE;
                                    r_busy   <= 1'b0;
                                end else begin
                                    r_char   <= r_char + 4'd1;
                                    r_shift  <= frame_char(r_char + 4'd1, r_snap, r_rs);
                                    r_tx     <= 1'b0;
                                    r_tstate <= T_START;
                                end
                            end
                            default: begin
                                r_tstate <= T_IDLE;
                                r_fstate <= F_DONE;
                                r_tx     <= 1'b1;
                                r_busy   <= 1'b0;
                            end
                        endcase
                    end
                end
                default: r_fstate <= F_IDLE;
            endcase
        end
    end

    assign uart_tx     = r_tx;
    assign busy        = r_busy;
    assign err_flag    = r_err_flag;
    assign err_count   = r_err_count;
    assign o_dbg_state = {r_fstate, r_tstate};
endmodule
